// File: rtl/load_unit.sv
// Load unit: checks a RISC-V load, issues one word read, waits with a timeout,
// then extracts and extends the addressed byte/halfword/word.
module load_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] daddr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [4:0]  rd_out,
  output logic        err
);

  localparam logic [4:0] TO_LIMIT = 5'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        f3_legal;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [4:0]  cnt_inc;

  // Opcode and immediate fields are decoded upstream.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:15], instr[6:0]};

  always_comb begin
    f3_legal   = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                 (funct3_q == 3'b100) || (funct3_q == 3'b101);
    misaligned = (((funct3_q == 3'b001) || (funct3_q == 3'b101)) && addr_q[0]) ||
                 ((funct3_q == 3'b010) && (addr_q[1:0] != 2'b00));
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  assign cnt_inc = cnt_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rd_out_d   = rd_out_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CHECK;
          funct3_d = instr[14:12];
          rd_out_d = instr[11:7];
          addr_d   = daddr;
          busy_d   = 1'b1;
        end
      end
      S_CHECK: begin
        if (!f3_legal || misaligned) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
          done_d  = 1'b1;
        end else begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = {addr_q[31:2], 2'b00};
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        cnt_d   = 5'd0;
      end
      S_WAIT: begin
        // A response on the final allowed cycle still counts as a hit.
        if (mem_rvalid) begin
          state_d = S_DONE;
          rdata_d = load_val;
          err_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_LIMIT) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = 32'h0;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      cnt_q      <= 5'd0;
      rd_out_q   <= 5'd0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_out_q   <= rd_out_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign rd_out   = rd_out_q;
  assign err      = err_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: transaction-level model drives a per-cycle compare,
// plus literal latency/result expectations on each directed load.
module tb_load_unit;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] daddr = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rvalid = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [4:0]  rd_out;
  logic        err;

  load_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .daddr(daddr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_req(mem_req),
    .mem_addr(mem_addr), .busy(busy), .done(done), .rdata(rdata),
    .rd_out(rd_out), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // current transaction as seen by the model; k = cycles since the accepting edge
  bit          tx_act = 1'b0;
  int          tx_e, tx_dk;
  bit          tx_ok, tx_err;
  logic [4:0]  tx_rd;
  logic [31:0] tx_addr, tx_rdata;

  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err = 1'b0;
  logic [4:0]  exp_rd = 5'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_bad(input logic [2:0] f3, input logic [31:0] a);
    bit legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    bit mis   = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
    return !legal || mis;
  endfunction

  function automatic logic [31:0] model_val(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  int k;
  logic e_busy, e_done, e_req;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rdata = 32'h0; exp_err = 1'b0; exp_rd = 5'd0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rd_out", rd_out, 0);
      chk("rst_err", err, 0);
    end else begin
      e_busy = 1'b0; e_done = 1'b0; e_req = 1'b0;
      if (tx_act) begin
        k = cyc - tx_e;
        if (k == 0) exp_rd = tx_rd;
        if (k >= 0 && k <= tx_dk) e_busy = 1'b1;
        if (k == tx_dk) begin
          e_done = 1'b1; exp_rdata = tx_rdata; exp_err = tx_err;
        end
        if (tx_ok && k == 1) e_req = 1'b1;
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("mem_req", mem_req, e_req);
      if (e_req) chk("mem_addr", mem_addr, tx_addr);
      if (!e_busy || e_done) begin
        chk("rdata", rdata, exp_rdata);
        chk("err", err, exp_err);
      end
      chk("rd_out", rd_out, exp_rd);
    end
  end

  // d: WAIT cycles before rvalid (-1 = never); lit_n: done at T+lit_n
  task automatic do_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] word, input int d, input bit noise,
                         input int lit_n, input logic [31:0] lit_rdata, input bit lit_err);
    int got;
    bit hit;
    instr = {17'h0, f3, rd, 7'b0000011};
    daddr = addr;
    start = 1'b1;
    tx_e = cyc + 1; tx_rd = rd; tx_addr = {addr[31:2], 2'b00};
    tx_ok = !model_bad(f3, addr);
    if (!tx_ok) begin
      tx_dk = 1; tx_err = 1'b1; tx_rdata = 32'h0;
    end else if (d >= 0 && d < TIMEOUT) begin
      tx_dk = 3 + d; tx_err = 1'b0; tx_rdata = model_val(f3, addr, word);
    end else begin
      tx_dk = 2 + TIMEOUT; tx_err = 1'b1; tx_rdata = 32'h0;
    end
    tx_act = 1'b1;
    got = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      hit = (d >= 0) && (i == 2 + d);
      mem_rvalid = hit || (noise && i <= 1);
      mem_rdata = hit ? word : $urandom;
      @(negedge clk);
      if (done) begin
        got = i;
        break;
      end
    end
    if (got < 0) begin
      chk("done_seen", 0, 1);
    end else begin
      chk("latency", got + 1, lit_n);
      chk("lit_rdata", rdata, lit_rdata);
      chk("lit_err", err, lit_err);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    tx_act = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got stuck expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    do_load(3'b000, 5'd1,  32'h0000_1003, 32'h80FF_1234, 0,  1'b0, 4,  32'hFFFF_FF80, 1'b0);
    do_load(3'b101, 5'd2,  32'h0000_2002, 32'hBEEF_0001, 0,  1'b0, 4,  32'h0000_BEEF, 1'b0);
    do_load(3'b001, 5'd3,  32'h0000_2002, 32'hBEEF_0001, 0,  1'b0, 4,  32'hFFFF_BEEF, 1'b0);
    do_load(3'b010, 5'd4,  32'h0000_3001, 32'h1111_2222, 0,  1'b0, 2,  32'h0,         1'b1);
    do_load(3'b011, 5'd5,  32'h0000_3000, 32'h1111_2222, 0,  1'b0, 2,  32'h0,         1'b1);
    do_load(3'b010, 5'd6,  32'h0000_3000, 32'h1234_5678, -1, 1'b0, 19, 32'h0,         1'b1);
    do_load(3'b010, 5'd7,  32'h0000_3000, 32'hDEAD_BEEF, 15, 1'b0, 19, 32'hDEAD_BEEF, 1'b0);
    do_load(3'b100, 5'd8,  32'h0000_1001, 32'h1234_80AB, 2,  1'b1, 6,  32'h0000_0080, 1'b0);
    do_load(3'b000, 5'd10, 32'h0000_1000, 32'hFFFF_FF7F, 0,  1'b1, 4,  32'h0000_007F, 1'b0);
    do_load(3'b001, 5'd11, 32'h0000_2001, 32'h1234_5678, 0,  1'b0, 2,  32'h0,         1'b1);
    do_load(3'b110, 5'd12, 32'h0000_2000, 32'h1234_5678, 0,  1'b1, 2,  32'h0,         1'b1);
    do_load(3'b111, 5'd13, 32'h0000_2000, 32'h1234_5678, 0,  1'b0, 2,  32'h0,         1'b1);
    do_load(3'b101, 5'd14, 32'h0000_2000, 32'h1234_8001, 1,  1'b0, 5,  32'h0000_8001, 1'b0);
    do_load(3'b001, 5'd15, 32'h0000_2000, 32'h1234_8001, 0,  1'b0, 4,  32'hFFFF_8001, 1'b0);
    do_load(3'b010, 5'd31, 32'h0000_3004, 32'h89AB_CDEF, 3,  1'b0, 7,  32'h89AB_CDEF, 1'b0);
    do_load(3'b100, 5'd16, 32'h0000_1002, 32'hC3FF_0000, 0,  1'b0, 4,  32'h0000_00FF, 1'b0);

    // start held high through a busy load, then reset in WAIT
    instr = {17'h0, 3'b010, 5'd9, 7'b0000011};
    daddr = 32'h0000_4000;
    start = 1'b1;
    tx_e = cyc + 1; tx_rd = 5'd9; tx_addr = 32'h0000_4000; tx_ok = 1'b1;
    tx_dk = 2 + TIMEOUT; tx_err = 1'b1; tx_rdata = 32'h0;
    tx_act = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0; tx_act = 1'b0; start = 1'b0;
    #1 chk("async_rst_busy", busy, 0);
    chk("async_rst_rd_out", rd_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 mem_rvalid = 1'b0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rdata", rdata, 0);
    repeat (3) @(posedge clk);
    #1;
    do_load(3'b000, 5'd20, 32'h0000_5002, 32'h0055_0000, 0, 1'b0, 4, 32'h0000_0055, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
